// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: forward selects, FSM states
// and the in-flight slot record tracked for EX/MEM/WB.
package hazard_ctrl_pkg;

  // Slot rd field is sized for the widest supported register file; narrower
  // addresses are zero-extended on entry.
  localparam int SLOT_AW = 8;

  typedef enum logic [1:0] {FWD_REGFILE, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_e;

  typedef enum logic {CTRL_RUN, CTRL_MEM_WAIT} ctrl_state_e;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               we;
    logic               is_load;
  } slot_t;

  function automatic logic slot_match(slot_t s, logic [SLOT_AW-1:0] rs, logic use_rs);
    return s.valid & s.we & (s.rd != '0) & (s.rd == rs) & use_rs;
  endfunction

  function automatic fwd_sel_e fwd_pick(logic m_ex, logic m_mem, logic m_wb);
    if (m_ex)  return FWD_EX;
    if (m_mem) return FWD_MEM;
    if (m_wb)  return FWD_WB;
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_slots.sv
// Three-entry shift register of in-flight producers (EX -> MEM -> WB).
// Holds everything while frozen; EX takes an empty slot when bubbled.
module hazard_slots
  import hazard_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  advance_i,
  input  logic  bubble_i,
  input  slot_t dec_i,
  output slot_t ex_o,
  output slot_t mem_o,
  output slot_t wb_o
);

  slot_t ex_q, mem_q, wb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (advance_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bubble_i ? '0 : dec_i;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: forwarding selects, load-use stalls,
// redirect flushes and memory-wait freeze, plus saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_we,
  input  logic              dec_is_load,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              stall_fetch,
  output logic              stall_decode,
  output logic              bubble_ex,
  output logic              flush_decode,
  output logic              freeze_all,
  output logic [1:0]        fwd_rs1,
  output logic [1:0]        fwd_rs2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  slot_t       ex_s, mem_s, wb_s, dec_s;
  ctrl_state_e state_q;
  logic        redirect_pend_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic [SLOT_AW-1:0] rs1_w, rs2_w;
  logic m1_ex, m1_mem, m1_wb, m2_ex, m2_mem, m2_wb;
  logic run_go, exit_wait, haz, stall, flush;
  fwd_sel_e fwd1, fwd2;

  assign rs1_w = SLOT_AW'(dec_rs1);
  assign rs2_w = SLOT_AW'(dec_rs2);

  always_comb begin
    dec_s         = '0;
    dec_s.valid   = dec_valid;
    dec_s.rd      = SLOT_AW'(dec_rd);
    dec_s.we      = dec_we;
    dec_s.is_load = dec_is_load;
  end

  assign m1_ex  = slot_match(ex_s,  rs1_w, dec_use_rs1);
  assign m1_mem = slot_match(mem_s, rs1_w, dec_use_rs1);
  assign m1_wb  = slot_match(wb_s,  rs1_w, dec_use_rs1);
  assign m2_ex  = slot_match(ex_s,  rs2_w, dec_use_rs2);
  assign m2_mem = slot_match(mem_s, rs2_w, dec_use_rs2);
  assign m2_wb  = slot_match(wb_s,  rs2_w, dec_use_rs2);

  // A cycle advances unless memory is busy; leaving MEM_WAIT is itself a run cycle.
  assign run_go    = (state_q == CTRL_RUN) & ~mem_busy;
  assign exit_wait = (state_q == CTRL_MEM_WAIT) & ~mem_busy;
  assign flush     = (run_go & ex_redirect) | (exit_wait & (redirect_pend_q | ex_redirect));

  always_comb begin
    fwd1 = FWD_REGFILE;
    fwd2 = FWD_REGFILE;
    haz  = 1'b0;
    if (FWD_EN) begin
      fwd1 = fwd_pick(m1_ex, m1_mem, m1_wb);
      fwd2 = fwd_pick(m2_ex, m2_mem, m2_wb);
      haz  = dec_valid & ex_s.is_load & (m1_ex | m2_ex);
    end else begin
      haz  = dec_valid & (m1_ex | m1_mem | m1_wb | m2_ex | m2_mem | m2_wb);
    end
  end

  // Redirect squashes the stalled instruction, so it wins over the stall.
  assign stall = haz & ~mem_busy & ~flush;

  hazard_slots u_slots (
    .clk       (clk),
    .rst       (rst),
    .advance_i (~mem_busy),
    .bubble_i  (~dec_valid | stall | flush),
    .dec_i     (dec_s),
    .ex_o      (ex_s),
    .mem_o     (mem_s),
    .wb_o      (wb_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= CTRL_RUN;
      redirect_pend_q <= 1'b0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      state_q <= mem_busy ? CTRL_MEM_WAIT : CTRL_RUN;
      if (exit_wait)     redirect_pend_q <= 1'b0;
      else if (mem_busy) redirect_pend_q <= redirect_pend_q | ex_redirect;
      if ((stall | mem_busy) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1))              flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_fetch  = stall;
  assign stall_decode = stall;
  assign bubble_ex    = stall;
  assign flush_decode = flush;
  assign freeze_all   = mem_busy;
  assign fwd_rs1      = fwd1;
  assign fwd_rs2      = fwd2;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two DUTs (forwarding / no-forwarding with 4-bit counters)
// driven by the same stimulus and checked against an in-flight-list model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dec_valid = 0, dec_use_rs1 = 0, dec_use_rs2 = 0, dec_we = 0, dec_is_load = 0;
  logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic ex_redirect = 0, mem_busy = 0;

  logic sf_a, sd_a, bx_a, fl_a, fz_a, sf_b, sd_b, bx_b, fl_b, fz_b;
  logic [1:0] f1_a, f2_a, f1_b, f2_b;
  logic [31:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .CNT_W(32), .FWD_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
    .dec_is_load(dec_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_fetch(sf_a), .stall_decode(sd_a), .bubble_ex(bx_a), .flush_decode(fl_a),
    .freeze_all(fz_a), .fwd_rs1(f1_a), .fwd_rs2(f2_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

  hazard_ctrl #(.REG_AW(5), .CNT_W(4), .FWD_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
    .dec_is_load(dec_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_fetch(sf_b), .stall_decode(sd_b), .bubble_ex(bx_b), .flush_decode(fl_b),
    .freeze_all(fz_b), .fwd_rs1(f1_b), .fwd_rs2(f2_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

  typedef struct packed {bit v; bit [4:0] rd; bit we; bit ld;} ent_t;
  typedef struct packed {
    bit sf; bit sd; bit bx; bit fl; bit fz; bit [1:0] f1; bit [1:0] f2;
    bit [63:0] sc; bit [63:0] fc;
  } obs_t;

  // Reference state: index 0 is the youngest in-flight producer.
  ent_t      pipe [2][3];
  bit        pend [2];
  bit [63:0] scnt [2];
  bit [63:0] fcnt [2];
  bit        fwd_en [2] = '{1'b1, 1'b0};
  bit [63:0] cmax   [2] = '{64'hFFFF_FFFF, 64'hF};

  obs_t  q_a[$], q_b[$];
  string q_tag[$];
  int nvec = 0, nerr = 0;

  function automatic void model_clear(int m);
    for (int k = 0; k < 3; k++) pipe[m][k] = '0;
    pend[m] = 0; scnt[m] = 0; fcnt[m] = 0;
  endfunction

  function automatic int youngest(int m, int rs, bit use_rs);
    if (!use_rs || rs == 0) return -1;
    for (int k = 0; k < 3; k++)
      if (pipe[m][k].v && pipe[m][k].we && int'(pipe[m][k].rd) == rs) return k;
    return -1;
  endfunction

  function automatic obs_t model_out(int m);
    obs_t o;
    int k1, k2;
    bit haz, st;
    o = '0;
    k1 = youngest(m, int'(dec_rs1), dec_use_rs1);
    k2 = youngest(m, int'(dec_rs2), dec_use_rs2);
    o.fz = mem_busy;
    o.fl = !mem_busy && (ex_redirect || pend[m]);
    if (fwd_en[m]) begin
      haz  = dec_valid && pipe[m][0].ld && (k1 == 0 || k2 == 0);
      o.f1 = (k1 < 0) ? 2'd0 : 2'(k1 + 1);
      o.f2 = (k2 < 0) ? 2'd0 : 2'(k2 + 1);
    end else begin
      haz  = dec_valid && (k1 >= 0 || k2 >= 0);
    end
    st = haz && !o.fz && !o.fl;
    o.sf = st; o.sd = st; o.bx = st;
    o.sc = scnt[m]; o.fc = fcnt[m];
    return o;
  endfunction

  function automatic void model_step(int m, obs_t o);
    if (!mem_busy) begin
      pipe[m][2] = pipe[m][1];
      pipe[m][1] = pipe[m][0];
      if (dec_valid && !o.sd && !o.fl) pipe[m][0] = '{1'b1, dec_rd, dec_we, dec_is_load};
      else                             pipe[m][0] = '0;
      pend[m] = 0;
    end else if (ex_redirect) begin
      pend[m] = 1;
    end
    if ((o.sd || o.fz) && scnt[m] < cmax[m]) scnt[m]++;
    if (o.fl && fcnt[m] < cmax[m]) fcnt[m]++;
  endfunction

  task automatic drive(input bit r, input bit dv, input int rs1, input int rs2,
                       input bit u1, input bit u2, input int rd, input bit we,
                       input bit ld, input bit redir, input bit busy, input string tag);
    obs_t o;
    @(posedge clk); #1;
    rst = r; dec_valid = dv; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_rd = 5'(rd); dec_we = we;
    dec_is_load = ld; ex_redirect = redir; mem_busy = busy;
    for (int m = 0; m < 2; m++) begin
      if (r) model_clear(m);
      o = model_out(m);
      if (m == 0) q_a.push_back(o); else q_b.push_back(o);
      if (!r) model_step(m, o);
    end
    q_tag.push_back(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic cmp(input string tag, input string who, input obs_t act, input obs_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut_%s: got sf/sd/bx=%0b%0b%0b fl=%0b fz=%0b f1=%0d f2=%0d sc=%0d fc=%0d, want sf/sd/bx=%0b%0b%0b fl=%0b fz=%0b f1=%0d f2=%0d sc=%0d fc=%0d",
               tag, who, act.sf, act.sd, act.bx, act.fl, act.fz, act.f1, act.f2, act.sc, act.fc,
               exp.sf, exp.sd, exp.bx, exp.fl, exp.fz, exp.f1, exp.f2, exp.sc, exp.fc);
    end
  endtask

  always @(negedge clk) begin
    if (q_a.size() > 0 && q_b.size() > 0 && q_tag.size() > 0) begin
      obs_t ea, eb, aa, ab;
      string t;
      ea = q_a.pop_front(); eb = q_b.pop_front(); t = q_tag.pop_front();
      aa = '{sf_a, sd_a, bx_a, fl_a, fz_a, f1_a, f2_a, 64'(sc_a), 64'(fc_a)};
      ab = '{sf_b, sd_b, bx_b, fl_b, fz_b, f1_b, f2_b, 64'(sc_b), 64'(fc_b)};
      cmp(t, "a", aa, ea);
      cmp(t, "b", ab, eb);
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");

    // T1: add x5 then add x6,x5,x5
    drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "t1_prod");
    for (int i = 0; i < 4; i++) drive(0, 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, "t1_cons");
    idle(4, "t1_drain");

    // T2: lw x5 then add x7,x5,x1
    drive(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, "t2_load");
    for (int i = 0; i < 4; i++) drive(0, 1, 5, 1, 1, 1, 7, 1, 0, 0, 0, "t2_use");
    idle(4, "t2_drain");

    // T3: x0 producer and consumer
    drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, "t3_prod");
    drive(0, 1, 0, 0, 1, 1, 3, 1, 0, 0, 0, "t3_cons");
    idle(4, "t3_drain");

    // T4: redirect on top of a load-use stall
    drive(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, "t4_load");
    drive(0, 1, 5, 0, 1, 0, 8, 1, 0, 1, 0, "t4_redir");
    idle(4, "t4_drain");

    // T5: three busy cycles with a redirect in the middle one
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t5_busy1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "t5_busy2");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t5_busy3");
    idle(3, "t5_exit");

    // T6: fresh counters, no-forwarding stall length, then reset mid-stall
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t6_reset");
    drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "t6_prod");
    for (int i = 0; i < 5; i++) drive(0, 1, 5, 0, 1, 1, 6, 1, 0, 0, 0, "t6_cons");
    drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "t6_prod2");
    drive(0, 1, 5, 0, 1, 1, 6, 1, 0, 0, 0, "t6_stall");
    drive(1, 1, 5, 0, 1, 1, 6, 1, 0, 0, 0, "t6_rst_mid");
    drive(0, 1, 5, 0, 1, 1, 6, 1, 0, 0, 0, "t6_after");
    idle(3, "t6_drain");

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "sat_stall");
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "sat_flush");
    idle(2, "sat_drain");

    for (int i = 0; i < 800; i++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0);
      drive(r, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 5) == 0), "random");
    end
    idle(2, "final");

    repeat (3) @(posedge clk);
    nvec++;
    if (q_a.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left, want 0", q_a.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
